// File: rtl/radio_rx_ctrl.sv
// Frame scheduler/validator for pulse-width radio channels: periodic scan, range check,
// last-good-value bank, consecutive-bad-frame failsafe and a level req/ack CPU read port.
module radio_rx_ctrl #(
  parameter int unsigned NCH      = 4,
  parameter logic [11:0] MIN_W    = 12'd900,
  parameter logic [11:0] MAX_W    = 12'd2100,
  parameter logic [7:0]  FAIL_CNT = 8'd50,
  parameter logic [15:0] SCAN_DIV = 16'd20000
) (
  input  logic             CLK_1M,
  input  logic             RESET,
  input  logic [32*NCH-1:0] CH_DATA,
  input  logic             RD_REQ,
  input  logic [2:0]       RD_ADDR,
  output logic             RD_ACK,
  output logic [31:0]      RD_DATA,
  output logic             FAILSAFE,
  output logic             FRAME_VALID,
  output logic [NCH-1:0]   CH_MASK
);

  localparam int unsigned AW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;

  state_t        state, state_n;
  logic [15:0]   cnt;
  logic          tick;
  logic [AW-1:0] idx;
  logic          last;
  logic [11:0]   bank [NCH];
  logic [7:0]    fail_cnt, fail_cnt_n;
  logic          cur_off;
  logic [11:0]   cur_w;
  logic          cur_good;
  logic [AW-1:0] ra;
  logic          ra_is_ch;
  logic [7:0]    mask8;
  logic [31:0]   rd_word;

  always_comb begin
    tick     = (cnt == SCAN_DIV - 16'd1);
    last     = (idx == AW'(NCH - 1));
    cur_off  = CH_DATA[32*idx + 31];
    cur_w    = CH_DATA[32*idx +: 12];
    cur_good = !cur_off && (cur_w >= MIN_W) && (cur_w <= MAX_W);
    fail_cnt_n = (fail_cnt >= FAIL_CNT) ? FAIL_CNT : fail_cnt + 8'd1;
  end

  // Read word is built from current registered state, so a read landing on a
  // bank write cycle naturally returns the pre-write value.
  always_comb begin
    ra       = RD_ADDR[AW-1:0];
    ra_is_ch = (32'(RD_ADDR) < NCH);
    mask8    = '0;
    mask8[NCH-1:0] = CH_MASK;
    if (ra_is_ch)
      rd_word = {FAILSAFE, ~CH_MASK[ra], 18'd0, bank[ra]};
    else
      rd_word = {FAILSAFE, 7'd0, fail_cnt, 8'd0, mask8};
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (tick) state_n = ST_SCAN;
      ST_SCAN:   if (last) state_n = ST_COMMIT;
      ST_COMMIT: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_1M) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK_1M) begin
    if (RESET) begin
      cnt         <= '0;
      idx         <= '0;
      for (int unsigned i = 0; i < NCH; i++) bank[i] <= '0;
      CH_MASK     <= '0;
      fail_cnt    <= FAIL_CNT;
      FAILSAFE    <= 1'b1;
      FRAME_VALID <= 1'b0;
      RD_ACK      <= 1'b0;
      RD_DATA     <= '0;
    end else begin
      cnt         <= tick ? '0 : cnt + 16'd1;
      FRAME_VALID <= (state == ST_COMMIT);
      case (state)
        ST_IDLE: idx <= '0;
        ST_SCAN: begin
          if (cur_good) bank[idx] <= cur_w;
          CH_MASK[idx] <= cur_good;
          idx          <= idx + AW'(1);
        end
        ST_COMMIT: begin
          if (&CH_MASK) begin
            fail_cnt <= '0;
            FAILSAFE <= 1'b0;
          end else begin
            fail_cnt <= fail_cnt_n;
            FAILSAFE <= (fail_cnt_n == FAIL_CNT);
          end
        end
        default: ;
      endcase

      if (!RD_ACK) begin
        if (RD_REQ) begin
          RD_ACK  <= 1'b1;
          RD_DATA <= rd_word;
        end
      end else begin
        RD_ACK <= RD_REQ;
      end
    end
  end

endmodule

// File: tb/tb_radio_rx_ctrl.sv
// Randomized self-checking bench for radio_rx_ctrl against a frame-level behavioural model.
module tb_radio_rx_ctrl;
  localparam int NCH  = 4;
  localparam int SD   = 40;
  localparam int FC   = 50;
  localparam int MINW = 900;
  localparam int MAXW = 2100;

  logic             CLK_1M = 1'b0;
  logic             RESET = 1'b1;
  logic [32*NCH-1:0] CH_DATA;
  logic             RD_REQ = 1'b0;
  logic [2:0]       RD_ADDR = 3'd0;
  logic             RD_ACK;
  logic [31:0]      RD_DATA;
  logic             FAILSAFE;
  logic             FRAME_VALID;
  logic [NCH-1:0]   CH_MASK;

  logic [31:0] ch_w [NCH];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int frames = 0;

  int m_bank [NCH];
  bit m_good [NCH];
  int m_fc;
  bit m_fs;

  radio_rx_ctrl #(
    .NCH(NCH), .MIN_W(12'(MINW)), .MAX_W(12'(MAXW)),
    .FAIL_CNT(8'(FC)), .SCAN_DIV(16'(SD))
  ) dut (
    .CLK_1M(CLK_1M), .RESET(RESET), .CH_DATA(CH_DATA),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA),
    .FAILSAFE(FAILSAFE), .FRAME_VALID(FRAME_VALID), .CH_MASK(CH_MASK)
  );

  always #5 CLK_1M = ~CLK_1M;

  always_comb begin
    CH_DATA = '0;
    for (int i = 0; i < NCH; i++) CH_DATA[32*i +: 32] = ch_w[i];
  end

  // cyc = number of clocks since the last clock that sampled RESET high
  always @(posedge CLK_1M) cyc <= RESET ? 0 : cyc + 1;

  task automatic step();
    @(posedge CLK_1M);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin m_bank[i] = 0; m_good[i] = 0; end
    m_fc = FC; m_fs = 1; frames = 0;
  endfunction

  function automatic void model_frame();
    bit all_good = 1;
    for (int i = 0; i < NCH; i++) begin
      int w = int'(ch_w[i][11:0]);
      bit g = !ch_w[i][31] && w >= MINW && w <= MAXW;
      if (g) m_bank[i] = w;
      m_good[i] = g;
      all_good &= g;
    end
    if (all_good) begin m_fc = 0; m_fs = 0; end
    else begin
      if (m_fc < FC) m_fc++;
      m_fs = (m_fc == FC);
    end
    frames++;
  endfunction

  function automatic logic [NCH-1:0] m_mask();
    logic [NCH-1:0] m = '0;
    for (int i = 0; i < NCH; i++) m[i] = m_good[i];
    return m;
  endfunction

  function automatic logic [31:0] exp_word(input int a);
    if (a < NCH) return {m_fs, !m_good[a], 18'd0, 12'(m_bank[a])};
    return {m_fs, 7'd0, 8'(m_fc), 8'd0, 8'(m_mask())};
  endfunction

  function automatic int exp_at();
    return frames * SD + NCH + 1;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(0, 7))
      0: w = 32'd899;
      1: w = 32'd900;
      2: w = 32'd2100;
      3: w = 32'd2101;
      default: w = 32'($urandom_range(800, 2200));
    endcase
    w = w | ($urandom & 32'h7FFF_F000);
    if ($urandom_range(0, 7) == 0) w[31] = 1'b1;
    return w;
  endfunction

  // Updates the model for the frame about to be scanned and waits for its FRAME_VALID.
  task automatic run_frame(output int at);
    model_frame();
    at = -1;
    for (int k = 0; k < 2*SD; k++) begin
      step();
      if (FRAME_VALID === 1'b1) begin at = cyc; break; end
    end
  endtask

  // Single read transaction; lat = cycles until RD_ACK, -1 if never.
  task automatic do_read(input int addr, output logic [31:0] d, output int lat);
    RD_ADDR = 3'(addr);
    RD_REQ  = 1'b1;
    lat = -1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (RD_ACK === 1'b1) begin lat = k; break; end
    end
    d = RD_DATA;
    RD_REQ = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bit early;
    for (int i = 0; i < NCH; i++) ch_w[i] = 32'd1500;
    RESET = 1'b1; step(); step();
    n_cmp++;
    if ({RD_ACK, RD_DATA, FAILSAFE, FRAME_VALID, CH_MASK} !== {1'b0, 32'd0, 1'b1, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_vals: got ack=%b data=%h fs=%b fv=%b mask=%h want 0/0/1/0/0",
               RD_ACK, RD_DATA, FAILSAFE, FRAME_VALID, CH_MASK);
    end
    RESET = 1'b0; model_reset();
    early = 0;
    for (int k = 0; k < SD + NCH; k++) begin
      if (FRAME_VALID !== 1'b0 || FAILSAFE !== 1'b1) early = 1;
      step();
    end
    if (FRAME_VALID !== 1'b0 || FAILSAFE !== 1'b1) early = 1;
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL reset_hold: got early frame/failsafe drop want none before cycle %0d", SD+NCH+1); end
    model_frame(); step();
    n_cmp++;
    if (FRAME_VALID !== 1'b1 || cyc != exp_at()) begin
      n_bad++; $display("FAIL first_frame: got fv=%b at cycle %0d want fv=1 at %0d", FRAME_VALID, cyc, exp_at());
    end
    n_cmp++;
    if (FAILSAFE !== 1'b0 || CH_MASK !== 4'hF) begin
      n_bad++; $display("FAIL first_frame_state: got fs=%b mask=%h want fs=0 mask=f", FAILSAFE, CH_MASK);
    end
    step();
    n_cmp++;
    if (FRAME_VALID !== 1'b0) begin n_bad++; $display("FAIL fv_pulse: got fv=%b want 0", FRAME_VALID); end
  endtask

  task automatic test_range();
    int w [4] = '{899, 900, 2100, 2101};
    int eb [4] = '{1500, 900, 2100, 2100};
    bit em [4] = '{0, 1, 1, 0};
    int at, lat;
    logic [31:0] d;
    for (int f = 0; f < 4; f++) begin
      ch_w[1] = 32'(w[f]);
      run_frame(at);
      n_cmp++;
      if (at != exp_at() || CH_MASK[1] !== em[f] || CH_MASK !== m_mask()) begin
        n_bad++; $display("FAIL range_mask w=%0d: got at=%0d mask=%h want at=%0d mask=%h", w[f], at, CH_MASK, exp_at(), m_mask());
      end
      do_read(1, d, lat);
      n_cmp++;
      if (lat != 1 || d[11:0] !== 12'(eb[f]) || d !== exp_word(1)) begin
        n_bad++; $display("FAIL range_bank w=%0d: got lat=%0d data=%h want lat=1 data=%h bank=%0d", w[f], lat, d, exp_word(1), eb[f]);
      end
    end
  endtask

  task automatic test_read();
    int at, lat;
    logic [31:0] d;
    for (int i = 0; i < NCH; i++) ch_w[i] = 32'd1500;
    ch_w[0] = 32'd1234;
    run_frame(at);
    do_read(0, d, lat);
    n_cmp++;
    if (lat != 1 || d !== 32'h0000_04D2) begin n_bad++; $display("FAIL read_ch0: got lat=%0d data=%h want lat=1 data=000004d2", lat, d); end
    do_read(7, d, lat);
    n_cmp++;
    if (lat != 1 || d[7:0] !== 8'h0F || d !== exp_word(7)) begin
      n_bad++; $display("FAIL read_status7: got lat=%0d data=%h want lat=1 data=%h", lat, d, exp_word(7));
    end
    for (int a = 1; a < 7; a++) begin
      do_read(a, d, lat);
      n_cmp++;
      if (lat != 1 || d !== exp_word(a)) begin n_bad++; $display("FAIL read_addr%0d: got lat=%0d data=%h want data=%h", a, lat, d, exp_word(a)); end
    end
  endtask

  task automatic test_hold();
    int at, lat;
    logic [31:0] d, old;
    old = exp_word(0);
    ch_w[0] = 32'd1777;
    RD_ADDR = 3'd0; RD_REQ = 1'b1;
    step();
    n_cmp++;
    if (RD_ACK !== 1'b1 || RD_DATA !== old) begin n_bad++; $display("FAIL hold_first: got ack=%b data=%h want 1/%h", RD_ACK, RD_DATA, old); end
    run_frame(at);
    step(); step();
    n_cmp++;
    if (RD_ACK !== 1'b1 || RD_DATA !== old) begin n_bad++; $display("FAIL hold_frozen: got ack=%b data=%h want 1/%h", RD_ACK, RD_DATA, old); end
    RD_REQ = 1'b0;
    step();
    n_cmp++;
    if (RD_ACK !== 1'b0) begin n_bad++; $display("FAIL hold_drop: got ack=%b want 0", RD_ACK); end
    do_read(0, d, lat);
    n_cmp++;
    if (lat != 1 || d !== exp_word(0) || d[11:0] !== 12'd1777) begin
      n_bad++; $display("FAIL hold_reread: got lat=%0d data=%h want data=%h", lat, d, exp_word(0));
    end
  endtask

  task automatic test_coincident();
    int at, lat, target;
    logic [31:0] d, old;
    target = (frames + 1) * SD;
    ch_w[0] = 32'd1111;
    for (int k = 0; k < 2*SD && cyc != target; k++) step();
    old = exp_word(0);
    RD_ADDR = 3'd0; RD_REQ = 1'b1;
    model_frame();
    step();
    n_cmp++;
    if (RD_ACK !== 1'b1 || RD_DATA !== old) begin n_bad++; $display("FAIL coincident_read: got ack=%b data=%h want 1/%h", RD_ACK, RD_DATA, old); end
    RD_REQ = 1'b0;
    frames--;
    run_frame(at);
    n_cmp++;
    if (at != exp_at()) begin n_bad++; $display("FAIL coincident_frame: got at=%0d want %0d", at, exp_at()); end
    do_read(0, d, lat);
    n_cmp++;
    if (lat != 1 || d !== exp_word(0)) begin n_bad++; $display("FAIL coincident_after: got data=%h want %h", d, exp_word(0)); end
  endtask

  task automatic test_failsafe();
    int at, lat;
    logic [31:0] d;
    bit bad_fs;
    for (int i = 0; i < NCH; i++) ch_w[i] = 32'd1500;
    run_frame(at);
    ch_w[2][31] = 1'b1;
    bad_fs = 0;
    for (int f = 0; f < 49; f++) begin
      run_frame(at);
      if (at != exp_at() || FAILSAFE !== m_fs || FAILSAFE !== 1'b0) bad_fs = 1;
    end
    n_cmp++;
    if (bad_fs) begin n_bad++; $display("FAIL fs_49frames: got early failsafe or misplaced frame want fs=0 throughout"); end
    do_read(NCH, d, lat);
    n_cmp++;
    if (d[23:16] !== 8'd49 || d[31] !== 1'b0 || d !== exp_word(NCH)) begin
      n_bad++; $display("FAIL fs_count49: got status=%h want %h", d, exp_word(NCH));
    end
    run_frame(at);
    n_cmp++;
    if (FAILSAFE !== 1'b1 || CH_MASK[2] !== 1'b0) begin n_bad++; $display("FAIL fs_50th: got fs=%b mask=%h want fs=1", FAILSAFE, CH_MASK); end
    run_frame(at);
    do_read(NCH, d, lat);
    n_cmp++;
    if (d[23:16] !== 8'(FC) || FAILSAFE !== 1'b1 || d !== exp_word(NCH)) begin
      n_bad++; $display("FAIL fs_saturate: got status=%h fs=%b want %h", d, FAILSAFE, exp_word(NCH));
    end
    ch_w[2][31] = 1'b0;
    run_frame(at);
    n_cmp++;
    if (FAILSAFE !== 1'b0) begin n_bad++; $display("FAIL fs_recover: got fs=%b want 0", FAILSAFE); end
    do_read(NCH, d, lat);
    n_cmp++;
    if (d[23:16] !== 8'd0 || d !== exp_word(NCH)) begin n_bad++; $display("FAIL fs_clear_cnt: got status=%h want %h", d, exp_word(NCH)); end
  endtask

  task automatic test_random();
    int at, lat;
    logic [31:0] d;
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < NCH; i++) ch_w[i] = rand_word();
      run_frame(at);
      n_cmp++;
      if (at != exp_at() || CH_MASK !== m_mask() || FAILSAFE !== m_fs) begin
        n_bad++; $display("FAIL rand_frame%0d: got at=%0d mask=%h fs=%b want at=%0d mask=%h fs=%b",
                          f, at, CH_MASK, FAILSAFE, exp_at(), m_mask(), m_fs);
      end
      for (int a = 0; a <= NCH; a++) begin
        do_read(a, d, lat);
        n_cmp++;
        if (lat != 1 || d !== exp_word(a)) begin
          n_bad++; $display("FAIL rand_read f%0d a%0d: got lat=%0d data=%h want data=%h", f, a, lat, d, exp_word(a));
        end
      end
    end
  endtask

  task automatic test_reset_midscan();
    int at, lat, target;
    logic [31:0] d;
    bit saw_fv;
    target = (frames + 1) * SD + 2;
    for (int i = 0; i < NCH; i++) ch_w[i] = 32'd1400 + 32'(i);
    RD_ADDR = 3'd0; RD_REQ = 1'b1;
    for (int k = 0; k < 2*SD && cyc != target; k++) step();
    RESET = 1'b1;
    step();
    n_cmp++;
    if ({RD_ACK, RD_DATA, FAILSAFE, FRAME_VALID, CH_MASK} !== {1'b0, 32'd0, 1'b1, 1'b0, 4'h0}) begin
      n_bad++; $display("FAIL midscan_reset: got ack=%b data=%h fs=%b fv=%b mask=%h want 0/0/1/0/0",
                        RD_ACK, RD_DATA, FAILSAFE, FRAME_VALID, CH_MASK);
    end
    RESET = 1'b0; RD_REQ = 1'b0; model_reset();
    saw_fv = 0;
    for (int k = 0; k < NCH + 3; k++) begin step(); if (FRAME_VALID !== 1'b0) saw_fv = 1; end
    n_cmp++;
    if (saw_fv) begin n_bad++; $display("FAIL midscan_nofv: got FRAME_VALID pulse want none"); end
    do_read(0, d, lat);
    n_cmp++;
    if (d !== exp_word(0)) begin n_bad++; $display("FAIL midscan_bank: got data=%h want %h", d, exp_word(0)); end
    run_frame(at);
    n_cmp++;
    if (at != exp_at() || CH_MASK !== m_mask() || FAILSAFE !== m_fs) begin
      n_bad++; $display("FAIL midscan_resume: got at=%0d mask=%h fs=%b want at=%0d mask=%h fs=%b",
                        at, CH_MASK, FAILSAFE, exp_at(), m_mask(), m_fs);
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) ch_w[i] = 32'd1500;
    model_reset();
    test_reset();
    test_range();
    test_read();
    test_hold();
    test_coincident();
    test_failsafe();
    test_random();
    test_reset_midscan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
